// File: rtl/seq_alu_if.sv
// Operand/result handshake bundle for seq_alu: master drives operations, slave is the ALU.
interface seq_alu_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       ALU_Sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] ALU_Out;
  logic [WIDTH-1:0] ALU_Out_hi;
  logic             flag_z;
  logic             flag_n;
  logic             flag_c;
  logic             flag_v;

  modport master (
    output in_valid, A, B, ALU_Sel, out_ready,
    input  in_ready, out_valid, ALU_Out, ALU_Out_hi, flag_z, flag_n, flag_c, flag_v
  );

  modport slave (
    input  in_valid, A, B, ALU_Sel, out_ready,
    output in_ready, out_valid, ALU_Out, ALU_Out_hi, flag_z, flag_n, flag_c, flag_v
  );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle ALU with valid/ready handshakes, status flags and bit-serial shifts.
// Define SEQ_ALU_MUL_EN to build the shift-and-add multiplier in opcode 111.
module seq_alu #(
  parameter int WIDTH = 8
) (
  input logic      clk,
  input logic      rst_n,
  seq_alu_if.slave bus
);
  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int MSB     = WIDTH - 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state;
  logic [2:0]         op;
  logic [WIDTH-1:0]   work;
  logic               carry;
  logic [SHAMT_W-1:0] cnt;
  logic [WIDTH-1:0]   res_lo;
  logic [WIDTH-1:0]   res_hi;
  logic               z, n, c, v;
  logic               out_valid_r;

  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH:0]     add_s;
  logic [WIDTH:0]     sub_s;
  logic [WIDTH-1:0]   imm_res;
  logic               imm_c;
  logic               imm_v;
  logic               iterate;
  logic [WIDTH-1:0]   step_res;
  logic               step_c;

`ifdef SEQ_ALU_MUL_EN
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_next;

  // One partial product: add the multiplicand into the high half when the
  // current multiplier bit (LSB) is set, then shift the whole product right.
  function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] p,
                                                  input logic [WIDTH-1:0]   m);
    logic [WIDTH:0] sum;
    sum = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
    return {sum, p[WIDTH-1:1]};
  endfunction

  assign prod_next = mul_step(prod, mcand);
`endif

  assign bus.in_ready   = (state == IDLE) && rst_n;
  assign bus.out_valid  = out_valid_r;
  assign bus.ALU_Out    = res_lo;
  assign bus.ALU_Out_hi = res_hi;
  assign bus.flag_z     = z;
  assign bus.flag_n     = n;
  assign bus.flag_c     = c;
  assign bus.flag_v     = v;

  // Result of the acceptance cycle: final value for single-cycle ops, first step for shifts.
  always_comb begin
    shamt   = bus.B[SHAMT_W-1:0];
    add_s   = {1'b0, bus.A} + {1'b0, bus.B};
    sub_s   = {1'b0, bus.A} - {1'b0, bus.B};
    imm_res = '0;
    imm_c   = 1'b0;
    imm_v   = 1'b0;
    iterate = 1'b0;
    case (bus.ALU_Sel)
      3'b000: begin
        imm_res = add_s[WIDTH-1:0];
        imm_c   = add_s[WIDTH];
        imm_v   = (bus.A[MSB] == bus.B[MSB]) && (add_s[MSB] != bus.A[MSB]);
      end
      3'b001: begin
        imm_res = sub_s[WIDTH-1:0];
        imm_c   = sub_s[WIDTH];
        imm_v   = (bus.A[MSB] != bus.B[MSB]) && (sub_s[MSB] != bus.A[MSB]);
      end
      3'b010: imm_res = bus.A & bus.B;
      3'b011: imm_res = bus.A | bus.B;
      3'b100: imm_res = bus.A;
      3'b101: begin
        if (shamt != '0) begin
          imm_res = bus.A << 1;
          imm_c   = bus.A[MSB];
          iterate = (shamt > SHAMT_W'(1));
        end else begin
          imm_res = bus.A;
        end
      end
      3'b110: begin
        if (shamt != '0) begin
          imm_res = bus.A >> 1;
          imm_c   = bus.A[0];
          iterate = (shamt > SHAMT_W'(1));
        end else begin
          imm_res = bus.A;
        end
      end
      default: begin
`ifdef SEQ_ALU_MUL_EN
        iterate = 1'b1;
`endif
      end
    endcase
  end

  always_comb begin
    step_res = (op == 3'b101) ? (work << 1) : (work >> 1);
    step_c   = (op == 3'b101) ? work[MSB] : work[0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      out_valid_r <= 1'b0;
      res_lo      <= '0;
      res_hi      <= '0;
      z           <= 1'b0;
      n           <= 1'b0;
      c           <= 1'b0;
      v           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            op    <= bus.ALU_Sel;
            work  <= imm_res;
            carry <= imm_c;
            cnt   <= shamt - SHAMT_W'(1);
`ifdef SEQ_ALU_MUL_EN
            if (bus.ALU_Sel == 3'b111) begin
              prod  <= mul_step({{WIDTH{1'b0}}, bus.B}, bus.A);
              mcand <= bus.A;
              cnt   <= '1;
            end
`endif
            if (iterate) begin
              state <= BUSY;
            end else begin
              state       <= DONE;
              out_valid_r <= 1'b1;
              res_lo      <= imm_res;
              res_hi      <= '0;
              z           <= (imm_res == '0);
              n           <= imm_res[MSB];
              c           <= imm_c;
              v           <= imm_v;
            end
          end
        end
        BUSY: begin
`ifdef SEQ_ALU_MUL_EN
          if (op == 3'b111) begin
            prod <= prod_next;
            cnt  <= cnt - SHAMT_W'(1);
            if (cnt == SHAMT_W'(1)) begin
              state       <= DONE;
              out_valid_r <= 1'b1;
              res_lo      <= prod_next[WIDTH-1:0];
              res_hi      <= prod_next[2*WIDTH-1:WIDTH];
              z           <= (prod_next[WIDTH-1:0] == '0);
              n           <= prod_next[MSB];
              c           <= |prod_next[2*WIDTH-1:WIDTH];
              v           <= 1'b0;
            end
          end else
`endif
          begin
            work  <= step_res;
            carry <= step_c;
            cnt   <= cnt - SHAMT_W'(1);
            if (cnt == SHAMT_W'(1)) begin
              state       <= DONE;
              out_valid_r <= 1'b1;
              res_lo      <= step_res;
              res_hi      <= '0;
              z           <= (step_res == '0);
              n           <= step_res[MSB];
              c           <= step_c;
              v           <= 1'b0;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_r <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, multi-cycle successor to the 8-bit combinational ALU.
- Same 3-bit opcode map. Adds:
  - WIDTH generalisation
  - valid/ready handshakes on input and output
  - status flags
  - iterative variable-distance shifts
  - optional shift-and-add multiplier in the spare 111 slot
- Sits between the register file and the writeback stage of the datapath controller.

Parameters:
WIDTH, 8, operand/result width; power of 2, >= 4
SHAMT_W, $clog2(WIDTH), shift-amount field width (derived, do not override)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
in_valid  input  1  operands/opcode valid
in_ready  output  1  block can accept an operation
A  input  WIDTH  operand A
B  input  WIDTH  operand B; for shifts only B[SHAMT_W-1:0] (shamt) is used
ALU_Sel  input  3  opcode
out_valid  output  1  result/flags valid
out_ready  input  1  consumer accepts result
ALU_Out  output  WIDTH  result (low half for multiply)
ALU_Out_hi  output  WIDTH  multiply high half; 0 for all other ops
flag_z  output  1  ALU_Out == 0
flag_n  output  1  ALU_Out[WIDTH-1]
flag_c  output  1  carry/borrow/shift-out/mul-overflow
flag_v  output  1  signed overflow (add/sub only)

Behaviour:
- Reset: synchronous on rising clk while rst_n=0.
  - Forces state IDLE.
  - out_valid, ALU_Out, ALU_Out_hi and all flags = 0.
  - in_ready = (state==IDLE) && rst_n, so in_ready is 0 during reset.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. On in_valid, capture A, B, ALU_Sel; go to DONE (L=1) or BUSY.
  - BUSY: in_ready=0, out_valid=0. Iterate until the count is exhausted, then go to DONE.
  - DONE: out_valid=1. ALU_Out, ALU_Out_hi and flags are held stable. On out_ready, go to IDLE. No new operation is accepted in the same cycle.
- Latency L = edges from acceptance to out_valid high:
  - 000 add A+B: L=1. C = carry-out. V = signed overflow.
  - 001 sub A-B: L=1. C = borrow (A<B unsigned). V = signed overflow.
  - 010 and, 011 or, 100 pass A: L=1. C=V=0.
  - 101 shl A by shamt: one bit per cycle. L = max(1, shamt). C = last bit shifted out; C=0 if shamt=0.
  - 110 shr (logical) A by shamt: one bit per cycle. L = max(1, shamt). C = last bit shifted out; C=0 if shamt=0. Zero-fill.
  - 111: see Optional Feature.
- Arithmetic:
  - Unsigned modulo 2^WIDTH.
  - Add/sub internal sum is WIDTH+1 bits.
  - Z and N are computed on ALU_Out only.
- Boundaries:
  - in_valid while not IDLE: ignored, not queued.
  - out_ready while not DONE: ignored.
  - Operands are captured at acceptance; later changes to A/B/ALU_Sel have no effect.
  - Reset asserted in BUSY or DONE aborts the operation. No output is produced; out_valid=0 after that edge.
  - shamt=0 returns A unchanged with L=1.

Optional Feature:
- Macro: SEQ_ALU_MUL_EN
- Defined: 111 = unsigned shift-and-add multiply, one partial product per cycle.
  - L = WIDTH.
  - {ALU_Out_hi, ALU_Out} = A*B (2*WIDTH bits).
  - C = |ALU_Out_hi. V=0.
  - Z and N are taken from the low half.
- Undefined: 111 returns 0 with L=1.
  - ALU_Out_hi=0, C=V=0, Z=1, N=0 (legacy behaviour).
  - No multiplier datapath is synthesised.

Test Plan:
1. WIDTH=8, add A=FF B=01, out_ready=1 -> ALU_Out=00, C=1, Z=1, V=0, N=0; out_valid exactly 1 edge after acceptance; in_ready high again the following cycle.
2. sub A=80 B=01 -> ALU_Out=7F, V=1, C=0, N=0. Then sub A=01 B=02 -> ALU_Out=FF, C=1, N=1, V=0.
3. shl A=81 B=03 -> ALU_Out=08, C=0, L=3. Then shr A=81 B=01 -> ALU_Out=40, C=1, L=1. Then shl A=81 B=00 -> ALU_Out=81, C=0, L=1.
4. mul A=10 B=20, SEQ_ALU_MUL_EN defined -> ALU_Out=00, ALU_Out_hi=02, C=1, Z=1, L=8. Same stimulus without the macro -> ALU_Out=00, ALU_Out_hi=00, C=0, Z=1, L=1.
5. Backpressure: add A=05 B=03 with out_ready=0 for 5 cycles, in_valid held high with new operands -> ALU_Out=08 held stable, in_ready=0 throughout, second op not accepted until the cycle after out_ready=1.
6. Reset mid-op: start mul (macro on), pull rst_n low for 1 edge at BUSY cycle 4 -> out_valid=0, all outputs 0; after rst_n=1, in_ready=1 and a fresh add A=02 B=02 returns ALU_Out=04.
